// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encodings, command/response bytes and frame helper for the PS/2 mouse host
package ps2_pkg;
    localparam logic [2:0] S_RESET_TX   = 3'd0;
    localparam logic [2:0] S_RESET_RESP = 3'd1;
    localparam logic [2:0] S_EN_TX      = 3'd2;
    localparam logic [2:0] S_EN_RESP    = 3'd3;
    localparam logic [2:0] S_STREAM     = 3'd4;
    localparam logic [2:0] S_ERROR      = 3'd5;
    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] ACK        = 8'hFA;
    localparam logic [7:0] BAT_OK     = 8'hAA;
    localparam logic [7:0] ID_MOUSE   = 8'h00;
    localparam logic [7:0] RESEND     = 8'hFE;
    // Host-to-device bits after the start bit: data LSB first, odd parity, stop
    function automatic logic [9:0] tx_frame(input logic [7:0] cmd);
        return {1'b1, ~^cmd, cmd};
    endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: device-to-host PS/2 frame receiver driven by synchronised clock falls
module ps2_frame_rx #(
    parameter int BIT_TIMEOUT = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fall,
    input  logic       data,
    input  logic       abort,
    output logic [7:0] rx_byte,
    output logic       valid,
    output logic       drop
);
    localparam int TW = $clog2(BIT_TIMEOUT) + 1;
    localparam logic [TW-1:0] TMAX = TW'(BIT_TIMEOUT - 1);
    logic          busy;
    logic [3:0]    cnt;
    logic [8:0]    sh;
    logic [TW-1:0] tmr;
    // Shift start..stop on clock falls; drop the frame on bad parity/stop or a stalled clock
    always_ff @(posedge clk) begin
        valid <= 1'b0;
        drop  <= 1'b0;
        if (rst || abort) begin
            busy <= 1'b0;
            cnt  <= '0;
            tmr  <= '0;
        end else if (fall) begin
            tmr <= '0;
            if (!busy) begin
                busy <= ~data;
                cnt  <= '0;
            end else if (cnt == 4'd9) begin
                busy    <= 1'b0;
                valid   <= data & ^sh;
                drop    <= ~(data & ^sh);
                rx_byte <= sh[7:0];
            end else begin
                sh  <= {data, sh[8:1]};
                cnt <= cnt + 4'd1;
            end
        end else if (busy) begin
            busy <= tmr != TMAX;
            drop <= tmr == TMAX;
            tmr  <= tmr + 1'b1;
        end
    end
endmodule

// File: rtl/ps2_mouse_host.sv
// ps2_mouse_host: PS/2 mouse host running the reset/enable script, then decoding stream packets
module ps2_mouse_host
    import ps2_pkg::*;
#(
    parameter int CLK_HZ         = 25_000_000,
    parameter int INHIBIT_CYCLES = 2500,
    parameter int BIT_TIMEOUT    = 5000,
    parameter int RESP_TIMEOUT   = 12_500_000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mouse_clk_in,
    input  logic       mouse_data_in,
    output logic       mouse_clk_out,
    output logic       mouse_clk_oe,
    output logic       mouse_data_out,
    output logic       mouse_data_oe,
    output logic       ready,
    output logic       error,
    output logic       pkt_valid,
    output logic [2:0] pkt_buttons,
    output logic [8:0] pkt_dx,
    output logic [8:0] pkt_dy,
    output logic [1:0] pkt_ovf
);
    localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TW = $clog2(RESP_TIMEOUT > BIT_TIMEOUT ? RESP_TIMEOUT : BIT_TIMEOUT) + 1;
    localparam int RW = $clog2(MAX_RETRIES) + 1;
    localparam logic [IW-1:0] INH = IW'(INHIBIT_CYCLES);
    localparam logic [TW-1:0] BT  = TW'(BIT_TIMEOUT);
    localparam logic [TW-1:0] RT  = TW'(RESP_TIMEOUT);
    localparam logic [RW-1:0] MR  = RW'(MAX_RETRIES);
    logic [1:0]    cs, ds, tx_ph, idx;
    logic          c_prev, fall, tx_st, resp_st, retry_now, rx_valid, rx_drop;
    logic [2:0]    state, retry_to;
    logic [3:0]    bit_idx;
    logic [IW-1:0] inh;
    logic [TW-1:0] tmr;
    logic [RW-1:0] retries;
    logic [6:0]    b0;
    logic [7:0]    b1, rx_byte, expect_b;
    logic [9:0]    frame;

    assign mouse_clk_out  = 1'b0;
    assign mouse_data_out = 1'b0;
    assign fall           = c_prev & ~cs[1];

    // Two-flop synchronisers plus an edge register for clock-fall detection
    always_ff @(posedge clk) begin
        if (rst) begin
            cs     <= 2'b11;
            ds     <= 2'b11;
            c_prev <= 1'b1;
        end else begin
            cs     <= {cs[0], mouse_clk_in};
            ds     <= {ds[0], mouse_data_in};
            c_prev <= cs[1];
        end
    end

    ps2_frame_rx #(.BIT_TIMEOUT(BIT_TIMEOUT)) u_rx (
        .clk(clk), .rst(rst), .fall(fall), .data(ds[1]), .abort(tx_st),
        .rx_byte(rx_byte), .valid(rx_valid), .drop(rx_drop)
    );

    // Current command frame, expected response byte and script-failure detection
    always_comb begin
        tx_st     = state == S_RESET_TX || state == S_EN_TX;
        resp_st   = state == S_RESET_RESP || state == S_EN_RESP;
        frame     = tx_frame(state == S_EN_TX ? CMD_ENABLE : CMD_RESET);
        expect_b  = idx == 2'd0 ? ACK : idx == 2'd1 ? BAT_OK : ID_MOUSE;
        retry_now = tx_st ? tx_ph != 2'd0 && (fall ? tx_ph == 2'd2 && ds[1] : tmr == BT)
                          : resp_st && (tmr == RT || (rx_valid && rx_byte != expect_b));
        retry_to  = state == S_EN_RESP && rx_valid && rx_byte == RESEND ? S_EN_TX : S_RESET_TX;
    end

    // Init script sequencer, command transmitter and stream packet assembler
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_RESET_TX;
            tx_ph         <= 2'd0;
            idx           <= 2'd0;
            bit_idx       <= 4'd0;
            inh           <= '0;
            tmr           <= '0;
            retries       <= '0;
            b0            <= '0;
            b1            <= '0;
            mouse_clk_oe  <= 1'b0;
            mouse_data_oe <= 1'b0;
            ready         <= 1'b0;
            error         <= 1'b0;
            pkt_valid     <= 1'b0;
            pkt_buttons   <= '0;
            pkt_dx        <= '0;
            pkt_dy        <= '0;
            pkt_ovf       <= '0;
        end else begin
            pkt_valid <= 1'b0;
            if (retry_now) begin
                mouse_clk_oe  <= 1'b0;
                mouse_data_oe <= 1'b0;
                tx_ph         <= 2'd0;
                inh           <= '0;
                tmr           <= '0;
                idx           <= 2'd0;
                if (retries >= MR) begin
                    state <= S_ERROR;
                    error <= 1'b1;
                end else begin
                    retries <= retries + 1'b1;
                    state   <= retry_to;
                end
            end else case (state)
                S_RESET_TX, S_EN_TX: begin
                    if (tx_ph == 2'd0) begin
                        if (inh == INH) begin
                            mouse_clk_oe  <= 1'b0;
                            mouse_data_oe <= 1'b1;
                            tx_ph         <= 2'd1;
                            bit_idx       <= 4'd0;
                            tmr           <= '0;
                        end else begin
                            mouse_clk_oe <= 1'b1;
                            inh          <= inh + 1'b1;
                        end
                    end else if (fall) begin
                        tmr <= '0;
                        if (tx_ph == 2'd1) begin
                            mouse_data_oe <= ~frame[bit_idx];
                            bit_idx       <= bit_idx + 4'd1;
                            tx_ph         <= bit_idx == 4'd9 ? 2'd2 : 2'd1;
                        end else begin
                            state <= state + 3'd1;
                            tx_ph <= 2'd0;
                            inh   <= '0;
                            idx   <= 2'd0;
                        end
                    end else tmr <= tmr + 1'b1;
                end
                S_RESET_RESP, S_EN_RESP: begin
                    if (rx_valid) begin
                        tmr <= '0;
                        if (state == S_EN_RESP) begin
                            state <= S_STREAM;
                            ready <= 1'b1;
                        end else if (idx == 2'd2) begin
                            state <= S_EN_TX;
                            idx   <= 2'd0;
                        end else idx <= idx + 2'd1;
                    end else tmr <= tmr + 1'b1;
                end
                S_STREAM: begin
                    if (rx_drop || (idx != 2'd0 && tmr == BT)) begin
                        idx <= 2'd0;
                        tmr <= '0;
                    end else if (rx_valid) begin
                        tmr <= '0;
                        if (idx == 2'd0) begin
                            b0  <= {rx_byte[7:4], rx_byte[2:0]};
                            idx <= rx_byte[3] ? 2'd1 : 2'd0;
                        end else if (idx == 2'd1) begin
                            b1  <= rx_byte;
                            idx <= 2'd2;
                        end else begin
                            idx         <= 2'd0;
                            pkt_valid   <= 1'b1;
                            pkt_buttons <= b0[2:0];
                            pkt_dx      <= {b0[3], b1};
                            pkt_dy      <= {b0[4], rx_byte};
                            pkt_ovf     <= b0[6:5];
                        end
                    end else tmr <= idx == 2'd0 || fall ? '0 : tmr + 1'b1;
                end
                S_ERROR: state <= S_ERROR;
                default: state <= S_ERROR;
            endcase
        end
    end
endmodule
